// File: rtl/reg_writeback.sv
// rtl/reg_writeback.sv - register bank write-port drain FIFO with pending-write scoreboard (optional FORWARD_EN)
module reg_writeback #(
  parameter int WIDTH      = 8,
  parameter int ADD_WIDTH  = 5,
  parameter int DEPTH      = 15,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 res_valid,
  output logic                 res_ready,
  input  logic [ADD_WIDTH-1:0] res_reg,
  input  logic [WIDTH-1:0]     res_data,
  input  logic                 wb_hold,
  output logic                 w_en,
  output logic [ADD_WIDTH-1:0] w_reg,
  output logic [WIDTH-1:0]     w_data,
  input  logic [ADD_WIDTH-1:0] chk_reg1,
  input  logic [ADD_WIDTH-1:0] chk_reg2,
  output logic                 pend1,
  output logic                 pend2,
  output logic [WIDTH-1:0]     fwd_data1,
  output logic [WIDTH-1:0]     fwd_data2
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0]   FULL_CNT = CNT_W'(FIFO_DEPTH);
  localparam logic [ADD_WIDTH:0] DEPTH_L  = (ADD_WIDTH+1)'(DEPTH);

  // Buffer storage and bookkeeping
  logic [ADD_WIDTH-1:0] reg_mem_q  [FIFO_DEPTH];
  logic [WIDTH-1:0]     data_mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic                 w_en_q, w_en_d;
  logic [ADD_WIDTH-1:0] w_reg_q, w_reg_d;
  logic [WIDTH-1:0]     w_data_q, w_data_d;

  logic accept;
  logic in_range;
  logic push;
  logic pop;

  // Acceptance is decided from count alone, so a same-edge pop never frees room for a push
  assign res_ready = (count_q != FULL_CNT);
  assign accept    = res_valid & res_ready;
  // Register 0 is hardwired and addresses at or above DEPTH do not exist: consume but drop
  assign in_range  = (res_reg != '0) && ({1'b0, res_reg} < DEPTH_L);
  assign push      = accept & in_range;
  assign pop       = (count_q != '0) & ~wb_hold;

  assign w_en   = w_en_q;
  assign w_reg  = w_reg_q;
  assign w_data = w_data_q;

`ifdef FORWARD_EN
  // Oldest-to-youngest walk so the last hit wins: in-flight write first, then FIFO head to tail
  function automatic logic [WIDTH:0] scan(input logic [ADD_WIDTH-1:0] chk);
    logic             hit;
    logic [WIDTH-1:0] d;
    logic [PTR_W-1:0] idx;
    hit = 1'b0;
    d   = '0;
    if (w_en_q && (w_reg_q == chk)) begin
      hit = 1'b1;
      d   = w_data_q;
    end
    for (int k = 0; k < FIFO_DEPTH; k++) begin
      idx = rd_ptr_q + PTR_W'(k);
      if ((CNT_W'(k) < count_q) && (reg_mem_q[idx] == chk)) begin
        hit = 1'b1;
        d   = data_mem_q[idx];
      end
    end
    if (chk == '0) begin
      hit = 1'b0;
      d   = '0;
    end
    return {hit, d};
  endfunction
`else
  // Presence-only match: any valid FIFO entry or the in-flight write
  function automatic logic [WIDTH:0] scan(input logic [ADD_WIDTH-1:0] chk);
    logic             hit;
    logic [PTR_W-1:0] idx;
    hit = w_en_q && (w_reg_q == chk);
    for (int k = 0; k < FIFO_DEPTH; k++) begin
      idx = rd_ptr_q + PTR_W'(k);
      if ((CNT_W'(k) < count_q) && (reg_mem_q[idx] == chk)) begin
        hit = 1'b1;
      end
    end
    if (chk == '0) begin
      hit = 1'b0;
    end
    return {hit, {WIDTH{1'b0}}};
  endfunction
`endif

  // Scoreboard lookup for decode read port 1
  always_comb begin
    {pend1, fwd_data1} = scan(chk_reg1);
  end

  // Scoreboard lookup for decode read port 2
  always_comb begin
    {pend2, fwd_data2} = scan(chk_reg2);
  end

  // Next-state for pointers, occupancy and the registered write port
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    w_en_d   = 1'b0;
    w_reg_d  = w_reg_q;
    w_data_d = w_data_q;
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
      w_en_d   = 1'b1;
      w_reg_d  = reg_mem_q[rd_ptr_q];
      w_data_d = data_mem_q[rd_ptr_q];
    end
    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // State registers; reset discards everything buffered or in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      w_en_q   <= 1'b0;
      w_reg_q  <= '0;
      w_data_q <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      w_en_q   <= w_en_d;
      w_reg_q  <= w_reg_d;
      w_data_q <= w_data_d;
    end
  end

  // Entry storage; contents are only observed when covered by count
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        reg_mem_q[i]  <= '0;
        data_mem_q[i] <= '0;
      end
    end else if (push) begin
      reg_mem_q[wr_ptr_q]  <= res_reg;
      data_mem_q[wr_ptr_q] <= res_data;
    end
  end

endmodule

// File: tb/tb_reg_writeback.sv
// tb/tb_reg_writeback.sv - directed self-checking bench for reg_writeback
module tb_reg_writeback;

`ifdef FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       res_valid;
  logic       res_ready;
  logic [4:0] res_reg;
  logic [7:0] res_data;
  logic       wb_hold;
  logic       w_en;
  logic [4:0] w_reg;
  logic [7:0] w_data;
  logic [4:0] chk_reg1, chk_reg2;
  logic       pend1, pend2;
  logic [7:0] fwd_data1, fwd_data2;

  int checks = 0;
  int errors = 0;

  reg_writeback #(.WIDTH(8), .ADD_WIDTH(5), .DEPTH(15), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .res_valid(res_valid), .res_ready(res_ready), .res_reg(res_reg), .res_data(res_data),
    .wb_hold(wb_hold),
    .w_en(w_en), .w_reg(w_reg), .w_data(w_data),
    .chk_reg1(chk_reg1), .chk_reg2(chk_reg2),
    .pend1(pend1), .pend2(pend2), .fwd_data1(fwd_data1), .fwd_data2(fwd_data2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [4:0] r, input logic [7:0] d);
    res_valid = v;
    res_reg   = r;
    res_data  = d;
  endtask

  logic [12:0] q[$];
  logic [12:0] head;
  int          pushed;
  int          written;
  logic        exp_wen;
  logic        acc;

  initial begin
    rst = 1'b1;
    drive(1'b0, 5'd0, 8'h00);
    wb_hold  = 1'b0;
    chk_reg1 = 5'd0;
    chk_reg2 = 5'd0;
    #1;
    chk("rst_wen", w_en, 0);
    chk("rst_wreg", w_reg, 0);
    chk("rst_wdata", w_data, 0);
    chk("rst_ready", res_ready, 1);
    chk("rst_pend1", pend1, 0);
    chk("rst_fwd1", fwd_data1, 0);
    tick;
    rst = 1'b0;

    // single write to reg 3
    chk_reg1 = 5'd3;
    drive(1'b1, 5'd3, 8'hA5);
    tick;
    drive(1'b0, 5'd0, 8'h00);
    chk("sw_wen_buf", w_en, 0);
    chk("sw_pend_buf", pend1, 1);
    tick;
    chk("sw_wen", w_en, 1);
    chk("sw_wreg", w_reg, 3);
    chk("sw_wdata", w_data, 8'hA5);
    chk("sw_pend_fly", pend1, 1);
    chk("sw_fwd_fly", fwd_data1, FWD ? 8'hA5 : 8'h00);
    tick;
    chk("sw_wen_done", w_en, 0);
    chk("sw_pend_done", pend1, 0);

    // reg 0 and out-of-range destinations are consumed and dropped
    drive(1'b1, 5'd0, 8'hFF);
    tick;
    drive(1'b1, 5'd15, 8'h11);
    tick;
    drive(1'b0, 5'd0, 8'h00);
    chk_reg1 = 5'd15;
    chk("oor_ready", res_ready, 1);
    chk("oor_pend15", pend1, 0);
    chk("oor_pend0", pend2, 0);
    tick;
    chk("oor_wen_a", w_en, 0);
    tick;
    chk("oor_wen_b", w_en, 0);

    // fill under hold, then drain in order
    wb_hold = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      chk("full_ready_pre", res_ready, 1);
      drive(1'b1, 5'(i), 8'(8'h40 + i));
      tick;
    end
    chk("full_ready", res_ready, 0);
    drive(1'b1, 5'd5, 8'h45);
    chk_reg1 = 5'd5;
    chk_reg2 = 5'd4;
    tick;
    chk("full_held_ready", res_ready, 0);
    chk("full_held_wen", w_en, 0);
    chk("full_pend5", pend1, 0);
    chk("full_pend4", pend2, 1);
    wb_hold = 1'b0;
    tick;
    chk("drain1_wen", w_en, 1);
    chk("drain1_reg", w_reg, 1);
    chk("drain1_data", w_data, 8'h41);
    chk("drain1_pend5", pend1, 0);
    chk("drain1_ready", res_ready, 1);
    tick;
    drive(1'b0, 5'd0, 8'h00);
    chk("drain2_reg", w_reg, 2);
    chk("drain2_pend5", pend1, 1);
    tick;
    chk("drain3_reg", w_reg, 3);
    tick;
    chk("drain4_reg", w_reg, 4);
    chk("drain4_wen", w_en, 1);
    tick;
    chk("drain5_wen", w_en, 1);
    chk("drain5_reg", w_reg, 5);
    chk("drain5_data", w_data, 8'h45);
    tick;
    chk("drain_end_wen", w_en, 0);
    chk("drain_end_pend", pend1, 0);

    // duplicate destinations: youngest data forwards
    wb_hold = 1'b1;
    drive(1'b1, 5'd5, 8'h10);
    tick;
    drive(1'b1, 5'd5, 8'h20);
    tick;
    drive(1'b0, 5'd0, 8'h00);
    chk_reg1 = 5'd5;
    chk_reg2 = 5'd6;
    #1;
    chk("fwd_pend1", pend1, 1);
    chk("fwd_data1", fwd_data1, FWD ? 8'h20 : 8'h00);
    chk("fwd_pend2", pend2, 0);
    chk("fwd_data2", fwd_data2, 0);
    wb_hold = 1'b0;
    tick;
    chk("fwd_w1_data", w_data, 8'h10);
    chk("fwd_w1_pend", pend1, 1);
    chk("fwd_w1_fwd", fwd_data1, FWD ? 8'h20 : 8'h00);
    tick;
    chk("fwd_w2_data", w_data, 8'h20);
    chk("fwd_w2_pend", pend1, 1);
    chk("fwd_w2_fwd", fwd_data1, FWD ? 8'h20 : 8'h00);
    tick;
    chk("fwd_end_pend", pend1, 0);
    chk("fwd_end_fwd", fwd_data1, 0);

    // reset mid-stream with entries buffered and a write in flight
    wb_hold = 1'b1;
    for (int i = 7; i <= 9; i++) begin
      drive(1'b1, 5'(i), 8'(8'h70 + i));
      tick;
    end
    drive(1'b0, 5'd0, 8'h00);
    wb_hold = 1'b0;
    tick;
    chk_reg1 = 5'd8;
    #1;
    chk("mid_wen_pre", w_en, 1);
    chk("mid_pend_pre", pend1, 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_wen", w_en, 0);
    chk("mid_rst_wreg", w_reg, 0);
    chk("mid_rst_ready", res_ready, 1);
    chk("mid_rst_pend", pend1, 0);
    tick;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick;
      chk("post_rst_wen", w_en, 0);
    end

    // wrap-around with random hold against a queue model
    pushed  = 0;
    written = 0;
    for (int cyc = 0; cyc < 80 && written < 10; cyc++) begin
      if (pushed < 10) drive(1'b1, 5'((pushed % 14) + 1), 8'(8'h50 + 3 * pushed));
      else drive(1'b0, 5'd0, 8'h00);
      wb_hold = 1'($urandom_range(0, 1));
      #1;
      chk("wrap_ready", res_ready, (q.size() != 4) ? 1 : 0);
      acc     = res_valid && (q.size() != 4);
      exp_wen = (q.size() != 0) && !wb_hold;
      tick;
      chk("wrap_wen", w_en, exp_wen);
      if (exp_wen) begin
        head = q.pop_front();
        chk("wrap_wreg", w_reg, head[12:8]);
        chk("wrap_wdata", w_data, head[7:0]);
        written++;
      end
      if (acc) begin
        q.push_back({res_reg, res_data});
        pushed++;
      end
    end
    drive(1'b0, 5'd0, 8'h00);
    chk("wrap_written", written, 10);
    chk("wrap_empty", q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
